// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the line-wide RAM arbiter and the arbiters reused
// for other shared buses.
package ram_arb_pkg;

    localparam int DEFAULT_LINE_WIDTH = 128;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_id_t;

    function automatic int strb_width(input int line_width);
        return line_width / 8;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a sole requester wins, a tie goes to the side that
// did not win last time. Output is one-hot or zero.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (&req) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

endmodule

// File: rtl/ram_line_arbiter.sv
// Shares the single-ported line RAM between icache and dcache, one transaction at a
// time: grant, one access cycle, wait for read data, then hold the response.
module ram_line_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 15,
    parameter int LINE_WIDTH   = DEFAULT_LINE_WIDTH,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    ic_req_valid_i,
    output logic                    ic_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   ic_addr_i,
    output logic                    ic_rsp_valid_o,
    input  logic                    ic_rsp_ready_i,
    output logic [LINE_WIDTH-1:0]   ic_rsp_data_o,
    input  logic                    dc_req_valid_i,
    output logic                    dc_req_ready_o,
    input  logic                    dc_req_we_i,
    input  logic [ADDR_WIDTH-1:0]   dc_addr_i,
    input  logic [LINE_WIDTH-1:0]   dc_wdata_i,
    input  logic [LINE_WIDTH/8-1:0] dc_wstrb_i,
    output logic                    dc_rsp_valid_o,
    input  logic                    dc_rsp_ready_i,
    output logic [LINE_WIDTH-1:0]   dc_rsp_data_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [LINE_WIDTH-1:0]   mem_wdata_o,
    output logic [LINE_WIDTH/8-1:0] mem_wstrb_o,
    output logic                    mem_rd_en_o,
    input  logic [LINE_WIDTH-1:0]   mem_rdata_i,
    input  logic                    prog_busy_i
);

    localparam int STRB_W = strb_width(LINE_WIDTH);
    localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    logic [1:0]            state_q;
    req_id_t               owner_q;
    req_id_t               last_grant_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic [LINE_WIDTH-1:0] rsp_data_q;
    logic [LAT_W-1:0]      lat_ctr_q;
    logic [1:0]            grant;
    logic                  owner_rsp_ready;

    // Gating with rst_ni keeps both readies low while reset is held.
    rr_arb2 u_arb (
        .req        ({dc_req_valid_i, ic_req_valid_i}),
        .last_grant (last_grant_q == REQ_DC),
        .enable     (rst_ni && (state_q == ST_IDLE) && !prog_busy_i),
        .grant      (grant)
    );

    assign ic_req_ready_o  = grant[0];
    assign dc_req_ready_o  = grant[1];
    assign owner_rsp_ready = (owner_q == REQ_IC) ? ic_rsp_ready_i : dc_rsp_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            owner_q      <= REQ_IC;
            last_grant_q <= REQ_DC;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rsp_data_q   <= '0;
            lat_ctr_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|grant) begin
                        owner_q      <= grant[1] ? REQ_DC : REQ_IC;
                        last_grant_q <= grant[1] ? REQ_DC : REQ_IC;
                        addr_q       <= grant[1] ? dc_addr_i : ic_addr_i;
                        we_q         <= grant[1] & dc_req_we_i;
                        wdata_q      <= grant[1] ? dc_wdata_i : '0;
                        wstrb_q      <= grant[1] ? dc_wstrb_i : '0;
                        state_q      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (we_q) begin
                        rsp_data_q <= '0;
                        state_q    <= ST_RESP;
                    end else begin
                        lat_ctr_q <= LAT_W'(READ_LATENCY - 1);
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_ctr_q == '0) begin
                        rsp_data_q <= mem_rdata_i;
                        state_q    <= ST_RESP;
                    end else begin
                        lat_ctr_q <= lat_ctr_q - LAT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (owner_rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The RAM writes whenever any strobe is set, so strobes exist only in ACCESS.
    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = wdata_q;
    assign mem_rd_en_o    = (state_q == ST_ACCESS) && !we_q;
    assign mem_wstrb_o    = ((state_q == ST_ACCESS) && we_q) ? wstrb_q : '0;

    assign ic_rsp_valid_o = (state_q == ST_RESP) && (owner_q == REQ_IC);
    assign dc_rsp_valid_o = (state_q == ST_RESP) && (owner_q == REQ_DC);
    assign ic_rsp_data_o  = ic_rsp_valid_o ? rsp_data_q : '0;
    assign dc_rsp_data_o  = dc_rsp_valid_o ? rsp_data_q : '0;

endmodule

// File: tb/tb_ram_line_arbiter.sv
// Bench for ram_line_arbiter: a line RAM model, a transaction-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_ram_line_arbiter;

    localparam int AW = 15;
    localparam int LW = 128;
    localparam int SW = 16;
    localparam int RL = 1;
    localparam logic [127:0] PAT = 128'hDDDD_CCCC_BBBB_AAAA_9999_8888_7777_6666;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          rst_ni;
    logic          ic_req_valid_i, ic_req_ready_o, ic_rsp_valid_o, ic_rsp_ready_i;
    logic [AW-1:0] ic_addr_i;
    logic [LW-1:0] ic_rsp_data_o;
    logic          dc_req_valid_i, dc_req_ready_o, dc_req_we_i, dc_rsp_valid_o, dc_rsp_ready_i;
    logic [AW-1:0] dc_addr_i;
    logic [LW-1:0] dc_wdata_i, dc_rsp_data_o;
    logic [SW-1:0] dc_wstrb_i;
    logic [AW-1:0] mem_addr_o;
    logic [LW-1:0] mem_wdata_o, mem_rdata_i;
    logic [SW-1:0] mem_wstrb_o;
    logic          mem_rd_en_o, prog_busy_i;

    // Second instance built with a 3-cycle RAM read latency
    logic          ic3_valid, ic3_ready, ic3_rsp_valid;
    logic [AW-1:0] ic3_addr, mem3_addr;
    logic [LW-1:0] ic3_rsp_data, dc3_rsp_data, mem3_wdata, mem3_rdata;
    logic          dc3_ready, dc3_rsp_valid, mem3_rd_en;
    logic [SW-1:0] mem3_wstrb;
    logic          zero1;
    logic [AW-1:0] zero_a;
    logic [LW-1:0] zero_l;
    logic [SW-1:0] zero_s;

    int checks = 0;
    int errors = 0;

    ram_line_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .READ_LATENCY(RL)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ic_req_valid_i(ic_req_valid_i), .ic_req_ready_o(ic_req_ready_o), .ic_addr_i(ic_addr_i),
        .ic_rsp_valid_o(ic_rsp_valid_o), .ic_rsp_ready_i(ic_rsp_ready_i), .ic_rsp_data_o(ic_rsp_data_o),
        .dc_req_valid_i(dc_req_valid_i), .dc_req_ready_o(dc_req_ready_o), .dc_req_we_i(dc_req_we_i),
        .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i), .dc_wstrb_i(dc_wstrb_i),
        .dc_rsp_valid_o(dc_rsp_valid_o), .dc_rsp_ready_i(dc_rsp_ready_i), .dc_rsp_data_o(dc_rsp_data_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_rd_en_o(mem_rd_en_o), .mem_rdata_i(mem_rdata_i), .prog_busy_i(prog_busy_i)
    );

    ram_line_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .READ_LATENCY(3)) dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ic_req_valid_i(ic3_valid), .ic_req_ready_o(ic3_ready), .ic_addr_i(ic3_addr),
        .ic_rsp_valid_o(ic3_rsp_valid), .ic_rsp_ready_i(1'b1), .ic_rsp_data_o(ic3_rsp_data),
        .dc_req_valid_i(zero1), .dc_req_ready_o(dc3_ready), .dc_req_we_i(zero1),
        .dc_addr_i(zero_a), .dc_wdata_i(zero_l), .dc_wstrb_i(zero_s),
        .dc_rsp_valid_o(dc3_rsp_valid), .dc_rsp_ready_i(1'b1), .dc_rsp_data_o(dc3_rsp_data),
        .mem_addr_o(mem3_addr), .mem_wdata_o(mem3_wdata), .mem_wstrb_o(mem3_wstrb),
        .mem_rd_en_o(mem3_rd_en), .mem_rdata_i(mem3_rdata), .prog_busy_i(zero1)
    );

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Line RAM model: one line per four word addresses, byte-strobed writes, registered reads
    logic [LW-1:0] ram  [0:8191];
    logic [LW-1:0] gold [0:8191];
    logic [LW-1:0] rd_pipe [0:RL-1];
    logic [LW-1:0] p3 [0:2];

    always @(posedge clk_i) begin
        logic [LW-1:0] line_v;
        if (|mem_wstrb_o) begin
            line_v = ram[mem_addr_o[AW-1:2]];
            for (int b = 0; b < SW; b++)
                if (mem_wstrb_o[b]) line_v[8*b +: 8] = mem_wdata_o[8*b +: 8];
            ram[mem_addr_o[AW-1:2]] = line_v;
        end
        for (int i = RL - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= mem_rd_en_o ? ram[mem_addr_o[AW-1:2]] : '0;
        p3[0] <= mem3_rd_en ? ram[mem3_addr[AW-1:2]] : '0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    assign mem_rdata_i = rd_pipe[RL-1];
    assign mem3_rdata  = p3[2];

    // Reference model: one outstanding transaction, response due 2 (+RL for reads)
    // cycles after its handshake, round-robin on ties, nothing while programming.
    bit            m_busy, m_owner_dc, m_we, m_last_dc;
    int            m_age;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata, m_exp;
    logic [SW-1:0] m_wstrb;

    always @(negedge clk_i) begin
        bit            win_ic, win_dc, rsp_v;
        int            rsp_age;
        logic [LW-1:0] line_v;
        if (!rst_ni) begin
            checkOutput("reset_outputs", {ic_req_ready_o, dc_req_ready_o, ic_rsp_valid_o, dc_rsp_valid_o,
                        mem_rd_en_o, |mem_wstrb_o, |mem_addr_o, |mem_wdata_o, |ic_rsp_data_o, |dc_rsp_data_o}, '0);
            m_busy = 0; m_last_dc = 1; m_addr = '0; m_age = 0; m_we = 0;
        end else begin
            if (m_busy) m_age++;
            win_ic = 0;
            win_dc = 0;
            if (!m_busy && !prog_busy_i) begin
                if (ic_req_valid_i && dc_req_valid_i) begin
                    if (m_last_dc) win_ic = 1; else win_dc = 1;
                end else begin
                    win_ic = ic_req_valid_i;
                    win_dc = dc_req_valid_i;
                end
            end
            rsp_age = m_we ? 2 : 2 + RL;
            rsp_v   = m_busy && (m_age >= rsp_age);
            checkOutput("ic_req_ready", ic_req_ready_o, win_ic);
            checkOutput("dc_req_ready", dc_req_ready_o, win_dc);
            checkOutput("mem_rd_en", mem_rd_en_o, m_busy && m_age == 1 && !m_we);
            checkOutput("mem_wstrb", mem_wstrb_o, (m_busy && m_age == 1 && m_we) ? m_wstrb : '0);
            checkOutput("mem_addr", mem_addr_o, m_addr);
            if (m_busy && m_age == 1 && m_we) checkOutput("mem_wdata", mem_wdata_o, m_wdata);
            checkOutput("ic_rsp_valid", ic_rsp_valid_o, rsp_v && !m_owner_dc);
            checkOutput("dc_rsp_valid", dc_rsp_valid_o, rsp_v && m_owner_dc);
            if (rsp_v) begin
                checkOutput("ic_rsp_data", ic_rsp_data_o, m_owner_dc ? '0 : m_exp);
                checkOutput("dc_rsp_data", dc_rsp_data_o, m_owner_dc ? m_exp : '0);
            end
            if (win_ic || win_dc) begin
                m_busy = 1; m_age = 0; m_owner_dc = win_dc; m_last_dc = win_dc;
                m_addr  = win_dc ? dc_addr_i : ic_addr_i;
                m_we    = win_dc && dc_req_we_i;
                m_wdata = dc_wdata_i;
                m_wstrb = dc_wstrb_i;
                if (m_we) begin
                    line_v = gold[m_addr[AW-1:2]];
                    for (int b = 0; b < SW; b++)
                        if (m_wstrb[b]) line_v[8*b +: 8] = m_wdata[8*b +: 8];
                    gold[m_addr[AW-1:2]] = line_v;
                    m_exp = '0;
                end else begin
                    m_exp = gold[m_addr[AW-1:2]];
                end
            end else if (rsp_v && (m_owner_dc ? dc_rsp_ready_i : ic_rsp_ready_i)) begin
                m_busy = 0;
            end
        end
    end

    task automatic applyStimulus(input bit ic_v, input logic [AW-1:0] ic_a, input bit dc_v, input bit we,
                                 input logic [AW-1:0] dc_a, input logic [LW-1:0] wd, input logic [SW-1:0] ws);
        ic_req_valid_i = ic_v; ic_addr_i = ic_a;
        dc_req_valid_i = dc_v; dc_req_we_i = we; dc_addr_i = dc_a;
        dc_wdata_i = wd; dc_wstrb_i = ws;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Waits (bounded) for the chosen side's ready; returns just after the handshake edge.
    task automatic waitGrant(input bit want_dc);
        bit ok;
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk_i);
            if (want_dc ? dc_req_ready_o : ic_req_ready_o) ok = 1;
        end
        if (!ok) checkOutput("grant_timeout", 0, 1);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int n, rdy, memact, lat;
        bit [3:0] order;
        bit got;
        for (int i = 0; i < 8192; i++) begin ram[i] = '0; gold[i] = '0; end
        ram[4] = PAT; gold[4] = PAT;
        for (int i = 0; i < RL; i++) rd_pipe[i] = '0;
        for (int i = 0; i < 3; i++) p3[i] = '0;
        zero1 = 0; zero_a = '0; zero_l = '0; zero_s = '0;
        ic3_valid = 0; ic3_addr = '0;
        rst_ni = 0; prog_busy_i = 0; ic_rsp_ready_i = 1; dc_rsp_ready_i = 1;
        applyStimulus(0, '0, 0, 0, '0, '0, '0);
        step(3);
        rst_ni = 1;
        step(1);

        // Both requesting from reset: IC first, then strict alternation
        applyStimulus(1, 15'h0020, 1, 0, 15'h0030, '0, '0);
        n = 0; order = '0;
        for (int c = 0; c < 100 && n < 4; c++) begin
            @(negedge clk_i);
            if (ic_req_ready_o) begin order[n] = 1'b0; n++; end
            else if (dc_req_ready_o) begin order[n] = 1'b1; n++; end
        end
        @(posedge clk_i); #1;
        applyStimulus(0, '0, 0, 0, '0, '0, '0);
        checkOutput("alt_grant_count", n, 4);
        checkOutput("alt_grant_order", order, 4'b1010);
        step(6);

        // IC read of 0x0010
        applyStimulus(1, 15'h0010, 0, 0, '0, '0, '0);
        waitGrant(0);
        applyStimulus(0, '0, 0, 0, '0, '0, '0);
        @(negedge clk_i);
        checkOutput("ic_rd_en_access", mem_rd_en_o, 1);
        checkOutput("ic_rd_addr", mem_addr_o, 15'h0010);
        @(negedge clk_i);
        checkOutput("ic_rd_en_wait", mem_rd_en_o, 0);
        checkOutput("ic_rsp_early", ic_rsp_valid_o, 0);
        @(negedge clk_i);
        checkOutput("ic_rsp_cycle3", ic_rsp_valid_o, 1);
        checkOutput("ic_rsp_line", ic_rsp_data_o, PAT);
        step(2);

        // DC write of word0 at 0x0004, then read it back
        applyStimulus(0, '0, 1, 1, 15'h0004, {96'h0, 32'h1234_5678}, 16'h000F);
        waitGrant(1);
        applyStimulus(0, '0, 0, 0, '0, '0, '0);
        @(negedge clk_i);
        checkOutput("wr_strb", mem_wstrb_o, 16'h000F);
        checkOutput("wr_no_rd_en", mem_rd_en_o, 0);
        @(negedge clk_i);
        checkOutput("wr_strb_off", mem_wstrb_o, 0);
        checkOutput("wr_ack_valid", dc_rsp_valid_o, 1);
        checkOutput("wr_ack_data", dc_rsp_data_o, 0);
        step(2);
        applyStimulus(0, '0, 1, 0, 15'h0004, '0, '0);
        waitGrant(1);
        applyStimulus(0, '0, 0, 0, '0, '0, '0);
        repeat (3) @(negedge clk_i);
        checkOutput("rdback_valid", dc_rsp_valid_o, 1);
        checkOutput("rdback_word0", dc_rsp_data_o[31:0], 32'h1234_5678);
        step(2);

        // Programming mode blocks grants; release grants in the same cycle
        prog_busy_i = 1;
        applyStimulus(1, 15'h0010, 1, 0, 15'h0004, '0, '0);
        rdy = 0; memact = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (ic_req_ready_o || dc_req_ready_o) rdy++;
            if (mem_rd_en_o || (|mem_wstrb_o)) memact++;
        end
        checkOutput("prog_no_ready", rdy, 0);
        checkOutput("prog_no_mem", memact, 0);
        @(posedge clk_i); #1;
        prog_busy_i = 0;
        @(negedge clk_i);
        checkOutput("prog_release_grant", ic_req_ready_o, 1);
        @(posedge clk_i); #1;
        applyStimulus(0, '0, 0, 0, '0, '0, '0);
        step(5);

        // DC response back-pressured for 5 cycles while IC waits
        dc_rsp_ready_i = 0;
        applyStimulus(0, '0, 1, 0, 15'h0004, '0, '0);
        waitGrant(1);
        applyStimulus(1, 15'h0010, 0, 0, '0, '0, '0);
        repeat (3) @(negedge clk_i);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk_i);
            checkOutput("bp_rsp_valid", dc_rsp_valid_o, 1);
            checkOutput("bp_rsp_data", dc_rsp_data_o[31:0], 32'h1234_5678);
            checkOutput("bp_ic_blocked", ic_req_ready_o, 0);
        end
        @(posedge clk_i); #1;
        dc_rsp_ready_i = 1;
        @(negedge clk_i);
        checkOutput("bp_no_grant_on_hs", ic_req_ready_o, 0);
        @(negedge clk_i);
        checkOutput("bp_grant_after_hs", ic_req_ready_o, 1);
        @(posedge clk_i); #1;
        applyStimulus(0, '0, 0, 0, '0, '0, '0);
        step(5);

        // Reset asserted while waiting for read data, then a fresh read
        applyStimulus(1, 15'h0010, 0, 0, '0, '0, '0);
        waitGrant(0);
        applyStimulus(0, '0, 0, 0, '0, '0, '0);
        @(posedge clk_i); #1;
        rst_ni = 0;
        #1;
        checkOutput("rst_in_wait", {ic_req_ready_o, dc_req_ready_o, ic_rsp_valid_o, dc_rsp_valid_o,
                    mem_rd_en_o, |mem_wstrb_o, |mem_addr_o}, '0);
        step(2);
        rst_ni = 1;
        step(1);
        applyStimulus(1, 15'h0010, 0, 0, '0, '0, '0);
        waitGrant(0);
        applyStimulus(0, '0, 0, 0, '0, '0, '0);
        repeat (3) @(negedge clk_i);
        checkOutput("post_rst_valid", ic_rsp_valid_o, 1);
        checkOutput("post_rst_line", ic_rsp_data_o, PAT);
        step(2);

        // READ_LATENCY = 3 instance: response five cycles after the handshake
        ic3_addr = 15'h0010;
        ic3_valid = 1;
        got = 0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk_i);
            if (ic3_ready) got = 1;
        end
        checkOutput("rl3_grant", got, 1);
        @(posedge clk_i); #1;
        ic3_valid = 0;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk_i);
            if (ic3_rsp_valid) lat = k;
        end
        checkOutput("rl3_latency", lat, 5);
        checkOutput("rl3_line", ic3_rsp_data, PAT);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_line_arbiter.md
Name: ram_line_arbiter

Overview:
- Sequences and shares the single-ported, line-wide program/data RAM between the instruction-cache and data-cache refill/writeback ports.
- Accepts one line request at a time via valid/ready, drives the RAM's address, write data, strobe and read-enable inputs, waits the fixed RAM read latency, and returns a response.
- Sits between the cache subsystem and the RAM.
- Blocks new grants while the RAM is in UART programming mode.

Parameters:
- ADDR_WIDTH, 15, word-address width (32K words).
- LINE_WIDTH, 128, cache line width in bits.
- READ_LATENCY, 1, cycles from RAM read-enable sample to valid read data; must be ≥1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- ic_req_valid_i  in  1  icache read request.
- ic_req_ready_o  out  1  icache request accepted.
- ic_addr_i  in  ADDR_WIDTH  icache word address.
- ic_rsp_valid_o  out  1  icache line response valid.
- ic_rsp_ready_i  in  1  icache takes response.
- ic_rsp_data_o  out  LINE_WIDTH  icache line data.
- dc_req_valid_i  in  1  dcache request.
- dc_req_ready_o  out  1  dcache request accepted.
- dc_req_we_i  in  1  1 = write, 0 = read.
- dc_addr_i  in  ADDR_WIDTH  dcache word address.
- dc_wdata_i  in  LINE_WIDTH  write line.
- dc_wstrb_i  in  LINE_WIDTH/8  byte strobes.
- dc_rsp_valid_o  out  1  dcache response (read data or write ack).
- dc_rsp_ready_i  in  1  dcache takes response.
- dc_rsp_data_o  out  LINE_WIDTH  dcache read line (0 for write ack).
- mem_addr_o  out  ADDR_WIDTH  RAM word address.
- mem_wdata_o  out  LINE_WIDTH  RAM write data.
- mem_wstrb_o  out  LINE_WIDTH/8  RAM byte strobes.
- mem_rd_en_o  out  1  RAM read enable.
- mem_rdata_i  in  LINE_WIDTH  RAM registered read data.
- prog_busy_i  in  1  RAM programming mode active; no new grants.

Behaviour:
- Reset (asynchronous, any state):
  - State IDLE; all outputs 0.
  - Captured request registers 0; last_grant = DC.
  - Any in-flight transaction is dropped.
- IDLE:
  - If prog_busy_i = 0 and at least one req_valid is high, grant a winner and assert only the winner's req_ready_o, combinationally in the same cycle.
  - A sole requester wins. On a tie, the requester not equal to last_grant wins (round-robin).
  - On handshake:
    - Capture id, addr, we (forced 0 for IC), wdata and wstrb.
    - Update last_grant.
    - Go to ACCESS.
  - If prog_busy_i = 1, both ready outputs are 0.
- ACCESS (exactly 1 cycle):
  - mem_addr_o = captured addr, passed unmodified; the RAM aligns to the line.
  - Read: mem_rd_en_o = 1, mem_wstrb_o = 0. Load lat_ctr = READ_LATENCY-1, go to WAIT.
  - Write: mem_wstrb_o = captured wstrb, mem_rd_en_o = 0. Go to RESP with rsp_data = 0.
  - A write with all-zero strobes still completes with an ack.
- WAIT:
  - When lat_ctr == 0: capture mem_rdata_i into rsp_data and go to RESP.
  - Otherwise decrement lat_ctr.
  - With READ_LATENCY = 1, WAIT lasts 1 cycle.
- RESP:
  - Assert the owner's rsp_valid_o; rsp_data_o is stable until the handshake.
  - The non-owner's rsp_valid_o is 0 and its rsp_data_o is 0.
  - When the owner's rsp_ready_i is high, go to IDLE. No grant is issued in that same cycle.
- Strobe and enable outside ACCESS:
  - mem_wstrb_o = 0 and mem_rd_en_o = 0 in every state except ACCESS. This is mandatory because the RAM writes whenever any strobe is set.
  - mem_addr_o and mem_wdata_o hold the captured values.
- prog_busy_i rising mid-transaction: the in-flight transaction completes normally; only the next grant is blocked.
- Latency and throughput:
  - Read: request handshake to rsp_valid = 2 + READ_LATENCY cycles.
  - Write: 2 cycles.
  - Maximum one transaction per 3 (write) or 3 + READ_LATENCY (read) cycles.
- Request inputs are sampled only at the handshake; later changes are ignored.

Decomposition:
- Package ram_arb_pkg holds:
  - state enum {IDLE, ACCESS, WAIT, RESP};
  - requester enum {REQ_IC, REQ_DC};
  - localparams derived from LINE_WIDTH (strobe width).
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], last_grant, enable.
  - Output: one-hot grant.
  - Reused later for peripheral bus sharing.

Test Plan:
- IC-only read, addr 0x0010, RAM model returns 0xDDDD_CCCC_BBBB_AAAA… → mem_rd_en_o pulses 1 cycle with mem_addr_o = 0x0010; ic_rsp_valid_o at cycle 3 after handshake carrying that line; mem_wstrb_o is 0 throughout.
- DC write, addr 0x0004, wstrb 0x000F, wdata word0 = 0x12345678 → mem_wstrb_o = 0x000F for exactly 1 cycle; dc_rsp_valid_o next cycle with data 0; a subsequent DC read of 0x0004 returns word0 = 0x12345678.
- IC and DC valid in the same cycle after reset → IC granted first; DC granted at the next IDLE; with both held continuously, grants alternate IC, DC, IC, DC.
- prog_busy_i = 1 with both valid → no ready for 20 cycles and mem_wstrb_o / mem_rd_en_o stay 0; deassert → grant on the same cycle.
- dc_rsp_ready_i held 0 for 5 cycles in RESP → dc_rsp_valid_o and data stable; IC request stays unready until the DC response handshake plus 1 cycle.
- rst_ni asserted during WAIT → all outputs 0 immediately; after release, a fresh IC read completes normally. READ_LATENCY = 3 build: read response at cycle 5.
